// File: rtl/seg7_scan_display_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_display_if
// Purpose  : Bundle of the CPU-side write strobe and the display drive lines
//            for the eight-digit scanned 7-segment driver.
// Revision : 1.0  initial release
// ============================================================================
interface seg7_scan_display_if;
  logic        cs;
  logic        i_valid;
  logic [31:0] i_data;
  logic [7:0]  o_seg;
  logic [7:0]  o_sel;
  logic        o_frame;

  // Board/CPU side drives the word and enable, observes the display lines.
  modport master (
    output cs, i_valid, i_data,
    input  o_seg, o_sel, o_frame
  );

  // Display driver side.
  modport slave (
    input  cs, i_valid, i_data,
    output o_seg, o_sel, o_frame
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_display
// Purpose  : Time-multiplexed driver for an eight-digit common-anode 7-segment
//            display showing a 32-bit word as hex. Writes land in a shadow
//            register and are promoted to the displayed word only at the
//            digit-7 -> digit-0 wrap, so a scan never shows a torn word.
// Options  : SEG_LZ_BLANK_EN - when defined, leading zero digits (1..7) are
//            blanked; digit 0 always shows.
// Revision : 1.0  initial release
// ============================================================================
module seg7_scan_display #(
  parameter int SCAN_CNT = 100000
) (
  input  wire logic          clk_in,
  input  wire logic          reset,
  seg7_scan_display_if.slave bus
);

  localparam int CNT_W = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CNT - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [31:0]      disp;
  logic [31:0]      pend;
  logic             pend_flag;

  logic             tick;
  logic             boundary;
  logic [3:0]       nibble;
  logic [7:0]       seg_hex;
  logic [7:0]       seg_next;
`ifdef SEG_LZ_BLANK_EN
  logic             digit_blank;
`endif

  // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp is never lit.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Scan timing decode and segment data for the digit currently indexed.
  always_comb begin
    tick     = (cnt == CNT_LAST);
    boundary = tick && (idx == 3'd7);
    nibble   = disp[{idx, 2'b00} +: 4];
    seg_hex  = hex_to_seg(nibble);
`ifdef SEG_LZ_BLANK_EN
    // A digit above 0 is blank when it and everything to its left is zero.
    digit_blank = (idx != 3'd0) && ((disp >> {idx, 2'b00}) == 32'd0);
    seg_next    = digit_blank ? 8'hFF : seg_hex;
`else
    seg_next    = seg_hex;
`endif
  end

  // Prescaler and digit index; the index advances once per digit period.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt <= '0;
      idx <= 3'd0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        idx <= idx + 3'd1;
      end
    end
  end

  // Shadow/display words: a write at the wrap bypasses the shadow register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      disp      <= 32'd0;
      pend      <= 32'd0;
      pend_flag <= 1'b0;
    end else if (boundary) begin
      if (bus.i_valid) begin
        disp <= bus.i_data;
      end else if (pend_flag) begin
        disp <= pend;
      end
      pend_flag <= 1'b0;
    end else if (bus.i_valid) begin
      pend      <= bus.i_data;
      pend_flag <= 1'b1;
    end
  end

  // Registered display drive, one cycle behind the index/word it shows.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      bus.o_seg   <= 8'hFF;
      bus.o_sel   <= 8'hFF;
      bus.o_frame <= 1'b0;
    end else begin
      bus.o_frame <= boundary;
      if (bus.cs) begin
        bus.o_sel <= ~(8'b1 << idx);
        bus.o_seg <= seg_next;
      end else begin
        bus.o_sel <= 8'hFF;
        bus.o_seg <= 8'hFF;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_display
// Purpose  : Self-checking bench for seg7_scan_display with SCAN_CNT=4.
//            Stimulus pushes the expected content of each scan frame into a
//            queue; a monitor captures every frame and compares on o_frame.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_display;

  localparam int SCAN_CNT = 4;

  // Expected frame images, digit 7 in the top byte, digit 0 in the bottom.
  localparam logic [63:0] E_1234 = 64'hF9A4B099_9282F880;
  localparam logic [63:0] E_DEAD = 64'hA18688A1_8386868E;
  localparam logic [63:0] E_9ABC = 64'h908883C6_C0F9A4B0;
  localparam logic [63:0] E_OFF  = 64'hFFFFFFFF_FFFFFFFF;
`ifdef SEG_LZ_BLANK_EN
  localparam logic [63:0] E_ZERO = 64'hFFFFFFFF_FFFFFFC0;
  localparam logic [63:0] E_000F = 64'hFFFFFFFF_FFFFFF8E;
  localparam logic [63:0] E_00F0 = 64'hFFFFFFFF_FFFF8EC0;
`else
  localparam logic [63:0] E_ZERO = 64'hC0C0C0C0_C0C0C0C0;
  localparam logic [63:0] E_000F = 64'hC0C0C0C0_C0C0C08E;
  localparam logic [63:0] E_00F0 = 64'hC0C0C0C0_C0C08EC0;
`endif

  typedef struct {
    logic [63:0] segs;
    int          blanks;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  exp_t exp_q[$];

  seg7_scan_display_if bus();

  seg7_scan_display #(.SCAN_CNT(SCAN_CNT)) dut (
    .clk_in (clk),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic push_exp(input logic [63:0] segs, input int blanks);
    exp_t e;
    e.segs   = segs;
    e.blanks = blanks;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if (bus.o_sel !== 8'hFF || bus.o_seg !== 8'hFF || bus.o_frame !== 1'b0) begin
      fails++;
      $display("FAIL %s: sel=%h seg=%h frame=%b, required sel=ff seg=ff frame=0",
               name, bus.o_sel, bus.o_seg, bus.o_frame);
    end
  endtask

  task automatic check_first_digit(input string name);
    tests++;
    if (bus.o_sel !== 8'hFE || bus.o_seg !== E_ZERO[7:0]) begin
      fails++;
      $display("FAIL %s: sel=%h seg=%h, required sel=fe seg=%h",
               name, bus.o_sel, bus.o_seg, E_ZERO[7:0]);
    end
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_frame === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL wait_frame: no o_frame within 100 cycles, required one per %0d", 8 * SCAN_CNT);
    end
  endtask

  task automatic write_at(input int n, input logic [31:0] d);
    repeat (n) @(posedge clk);
    #1;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_data  = 32'd0;
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    logic [7:0] cap [8];
    int         selc [8];
    int         samples;
    int         blanks;
    int         frame_no;
    bit         armed;
    bit         incons;
    bit         badsel;
    bit         found;
    bit         shape_ok;
    logic [7:0] onehot;
    logic [63:0] got;
    exp_t       e;

    armed    = 1'b0;
    frame_no = 0;
    samples  = 0;
    blanks   = 0;
    incons   = 1'b0;
    badsel   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cap[k]  = 8'hFF;
      selc[k] = 0;
    end

    forever begin
      @(negedge clk);
      if (reset) begin
        armed   = 1'b0;
        samples = 0;
        blanks  = 0;
        incons  = 1'b0;
        badsel  = 1'b0;
        for (int k = 0; k < 8; k++) begin
          cap[k]  = 8'hFF;
          selc[k] = 0;
        end
      end else begin
        if (!armed && bus.o_sel !== 8'hFF) armed = 1'b1;
        if (armed) begin
          samples++;
          if (bus.o_sel === 8'hFF) begin
            blanks++;
            if (bus.o_seg !== 8'hFF) incons = 1'b1;
          end else begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
              onehot = ~(8'h01 << k);
              if (bus.o_sel === onehot) begin
                found = 1'b1;
                selc[k]++;
                if (selc[k] == 1) cap[k] = bus.o_seg;
                else if (cap[k] !== bus.o_seg) incons = 1'b1;
              end
            end
            if (!found) badsel = 1'b1;
          end

          if (bus.o_frame === 1'b1) begin
            for (int k = 0; k < 8; k++) got[8*k +: 8] = cap[k];
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL frame%0d_unexpected: frame %h ended with no expectation queued",
                       frame_no, got);
            end else begin
              e = exp_q.pop_front();
              if (got !== e.segs) begin
                fails++;
                $display("FAIL frame%0d_segs: got %h, required %h", frame_no, got, e.segs);
              end
              tests++;
              shape_ok = (samples == 8 * SCAN_CNT) && (blanks == e.blanks) && !incons && !badsel;
              for (int k = 0; k < 8; k++)
                if (selc[k] != ((e.blanks == 8 * SCAN_CNT) ? 0 : SCAN_CNT)) shape_ok = 1'b0;
              if (!shape_ok) begin
                fails++;
                $display("FAIL frame%0d_shape: cycles=%0d blanks=%0d incons=%0b badsel=%0b sel0cnt=%0d, required cycles=%0d blanks=%0d incons=0 badsel=0 selcnt=%0d",
                         frame_no, samples, blanks, incons, badsel, selc[0], 8 * SCAN_CNT,
                         e.blanks, (e.blanks == 8 * SCAN_CNT) ? 0 : SCAN_CNT);
              end
            end
            frame_no++;
            samples = 0;
            blanks  = 0;
            incons  = 1'b0;
            badsel  = 1'b0;
            for (int k = 0; k < 8; k++) begin
              cap[k]  = 8'hFF;
              selc[k] = 0;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin : stimulus
    tests       = 0;
    fails       = 0;
    reset       = 1'b1;
    bus.cs      = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = 32'd0;

    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset_hold");
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_exp(E_ZERO, 0);                       // F0: display cleared by reset
    @(negedge clk);
    @(negedge clk);
    check_first_digit("first_after_reset");

    write_at(12, 32'h12345678);                // lands while idx==3
    wait_frame();
    push_exp(E_1234, 0);                       // F1
    write_at(5, 32'hAAAAAAAA);
    write_at(10, 32'h0000000F);                // last write in frame wins
    wait_frame();
    push_exp(E_000F, 0);                       // F2
    write_at(9, 32'h11111111);                 // pending word ...
    write_at(21, 32'hDEADBEEF);                // ... overridden on the wrap cycle
    wait_frame();
    push_exp(E_DEAD, 0);                       // F3: bypass write
    wait_frame();
    push_exp(E_DEAD, 0);                       // F4: stale pending word not reloaded
    wait_frame();
    bus.cs = 1'b0;
    push_exp(E_OFF, 8 * SCAN_CNT);             // F5: display disabled
    write_at(10, 32'h9ABC0123);
    wait_frame();
    bus.cs = 1'b1;
    push_exp(E_9ABC, 0);                       // F6: write taken while disabled
    write_at(3, 32'h000000F0);
    wait_frame();
    push_exp(E_00F0, 0);                       // F7
    write_at(3, 32'h00000000);
    wait_frame();
    push_exp(E_ZERO, 0);                       // F8: cut short by reset
    write_at(10, 32'h55555555);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("reset_mid_frame");
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_exp(E_ZERO, 0);                       // F9: pending word discarded
    @(negedge clk);
    @(negedge clk);
    check_first_digit("first_after_mid_reset");
    wait_frame();
    push_exp(E_ZERO, 0);                       // F10: still nothing reloaded
    wait_frame();
    @(negedge clk);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d frames outstanding, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
